ysyx_25020037_ifu: RTL and testbench

YSYX_25020037_IFU -- requirements
Module: ysyx_25020037_ifu

---
 rtl/ysyx_25020037_ifu_pkg.sv | 22 ++
 rtl/ysyx_25020037_ifu.sv | 136 +++++++++++++
 tb/tb_ysyx_25020037_ifu.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_ifu_pkg.sv
// rtl/ysyx_25020037_ifu_pkg.sv - shared fetch/decode configuration: FSM encodings, reset PC, bus width
//
// Imported by the instruction fetch unit and by the decode stage, so both
// agree on the {pc, inst} bus layout and width.

package ysyx_25020037_ifu_pkg;

    // First fetch address after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

    // fu_to_du_bus width, packed {pc[31:0], inst[31:0]}
    localparam int FU_TO_DU_BUS_WD = 64;

    // Fetch FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        S_AR   = 2'd0,  // address phase: arvalid high
        S_R    = 2'd1,  // data phase: rready high
        S_OUT  = 2'd2,  // instruction presented to decode
        S_WAIT = 2'd3   // handed off, waiting for the next redirect
    } ifu_state_t;

endpackage

// File: rtl/ysyx_25020037_ifu.sv
// rtl/ysyx_25020037_ifu.sv - instruction fetch unit, one AXI-style read per redirect
//
// Fetches one instruction per redirect from the write-back stage and hands
// it to decode as {pc, inst}. There is no speculative fetch: after decode
// accepts an instruction the unit idles until a next-PC redirect arrives.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   BUS_WD    fu_to_du_bus width ({pc, inst})
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   npc_valid, npc      next-PC redirect pulse and address
//   idu_ready           decode accepts the current bus
//   ifu_valid           fu_to_du_bus holds a fetched instruction
//   fu_to_du_bus        {pc, inst} to decode
//   ifu_fault           fetch returned nonzero rresp (qualified by ifu_valid)
//   araddr, arvalid,
//   arready             read address channel
//   rdata, rresp,
//   rvalid, rready      read data channel
//   perf_fetch_cnt      (YSYX_25020037_IFU_PERF_EN) completed fetches
//   perf_wait_cnt       (YSYX_25020037_IFU_PERF_EN) cycles waiting for rvalid
//
// Optional feature macro: YSYX_25020037_IFU_PERF_EN

module ysyx_25020037_ifu
    import ysyx_25020037_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          BUS_WD   = FU_TO_DU_BUS_WD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              npc_valid,
    input  logic [31:0]       npc,
    input  logic              idu_ready,
    output logic              ifu_valid,
    output logic [BUS_WD-1:0] fu_to_du_bus,
    output logic              ifu_fault,
    output logic [31:0]       araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
`ifdef YSYX_25020037_IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_wait_cnt
`endif
);

    ifu_state_t  state;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pend_pc;
    logic        pend_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_AR;
            pc        <= RESET_PC;
            inst      <= 32'h0;
            pend_pc   <= 32'h0;
            pend_v    <= 1'b0;
            ifu_fault <= 1'b0;
        end else begin
            case (state)
                S_AR: begin
                    if (arready) begin
                        state <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        // A faulted fetch hands decode a zero word, never the bad data
                        inst      <= (rresp != 2'b00) ? 32'h0 : rdata;
                        ifu_fault <= (rresp != 2'b00);
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (idu_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A live redirect wins over one parked earlier
                    if (npc_valid) begin
                        pc     <= npc;
                        pend_v <= 1'b0;
                        state  <= S_AR;
                    end else if (pend_v) begin
                        pc     <= pend_pc;
                        pend_v <= 1'b0;
                        state  <= S_AR;
                    end
                end
                default: state <= S_AR;
            endcase

            // Redirects arriving mid-transaction are parked so pc (and thus
            // araddr and the bus pc field) stays stable; the newest one wins.
            if (npc_valid && state != S_WAIT) begin
                pend_pc <= npc;
                pend_v  <= 1'b1;
            end
        end
    end

    // Handshake outputs are pure decodes of the state register, which keeps
    // arvalid and rready mutually exclusive and allows one read in flight.
    assign arvalid      = (state == S_AR) && !rst;
    assign rready       = (state == S_R);
    assign ifu_valid    = (state == S_OUT);
    assign araddr       = pc;
    assign fu_to_du_bus = {pc, inst};

`ifdef YSYX_25020037_IFU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_wait_cnt  <= 32'h0;
        end else if (state == S_R) begin
            if (rvalid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end else begin
                perf_wait_cnt  <= perf_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// tb/tb_ysyx_25020037_ifu.sv - self-checking bench for ysyx_25020037_ifu

module tb_ysyx_25020037_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        npc_valid;
    logic [31:0] npc;
    logic        idu_ready;
    logic        ifu_valid;
    logic [63:0] fu_to_du_bus;
    logic        ifu_fault;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
`ifdef YSYX_25020037_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    ysyx_25020037_ifu #(.RESET_PC(RST_PC), .BUS_WD(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .npc_valid    (npc_valid),
        .npc          (npc),
        .idu_ready    (idu_ready),
        .ifu_valid    (ifu_valid),
        .fu_to_du_bus (fu_to_du_bus),
        .ifu_fault    (ifu_fault),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready)
`ifdef YSYX_25020037_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Redirect timing for the fetch that follows a vector:
    // 0 pulse in S_WAIT after idle cycles, 1 pulse in S_R, 2 pulse in S_OUT,
    // 3 pulse together with idu_ready, 4 pulse in S_AR,
    // 5 decoy in S_R then live pulse in S_WAIT, 6 decoy in S_R then real in S_OUT
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          ar_dly;
        int          r_dly;
        int          idu_dly;
        int          phase;
        logic [31:0] pulse_pc;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int model_fetch = 0;
    int model_wait  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        npc_valid = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] p);
        npc_valid = 1'b1;
        npc       = p;
    endtask

    // One full fetch from address a; ends with the DUT in S_AR for the next one
    task automatic run_fetch(input logic [31:0] a, input vec_t v);
        int          n;
        logic [63:0] bus_exp;
        n = 0;
        while (!arvalid && n < 20) begin
            step();
            n++;
        end
        chk("arvalid_up", arvalid, 1);
        chk("araddr", araddr, a);
        chk("ar_no_rready", rready, 0);
        for (int i = 0; i < v.ar_dly; i++) begin
            if (v.phase == 4 && i == 0) pulse(v.pulse_pc);
            step();
            chk("ar_hold_valid", arvalid, 1);
            chk("ar_hold_addr", araddr, a);
            chk("ar_hold_rready", rready, 0);
        end
        if (v.phase == 4 && v.ar_dly == 0) pulse(v.pulse_pc);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("r_rready", rready, 1);
        chk("r_arvalid", arvalid, 0);
        chk("r_ifu_valid", ifu_valid, 0);
        if (v.phase == 1) pulse(v.pulse_pc);
        if (v.phase == 5 || v.phase == 6) pulse(v.pulse_pc ^ 32'h0000_0080);
        for (int i = 0; i < v.r_dly; i++) begin
            step();
            model_wait++;
            chk("r_wait_rready", rready, 1);
            chk("r_wait_arvalid", arvalid, 0);
        end
        rvalid = 1'b1;
        rdata  = v.data;
        rresp  = v.resp;
        step();
        model_fetch++;
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'($urandom);
        bus_exp = {a, v.exp_inst};
        chk("out_valid", ifu_valid, 1);
        chk("out_bus", fu_to_du_bus, bus_exp);
        chk("out_fault", ifu_fault, v.exp_fault);
        chk("out_rready", rready, 0);
        if (v.phase == 2 || v.phase == 6) pulse(v.pulse_pc);
        for (int i = 0; i < v.idu_dly; i++) begin
            step();
            chk("hold_valid", ifu_valid, 1);
            chk("hold_bus", fu_to_du_bus, bus_exp);
        end
        idu_ready = 1'b1;
        if (v.phase == 3) pulse(v.pulse_pc);
        step();
        idu_ready = 1'b0;
        chk("wait_valid", ifu_valid, 0);
        chk("wait_arvalid", arvalid, 0);
        if (v.phase == 0) begin
            repeat (2) begin
                step();
                chk("wait_idle", arvalid, 0);
            end
            pulse(v.pulse_pc);
        end else if (v.phase == 5) begin
            pulse(v.pulse_pc);
        end
        step();
        chk("next_arvalid", arvalid, 1);
        chk("next_araddr", araddr, v.pulse_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[6];
        vec_t        rv;
        logic [31:0] cur;

        tbl[0] = '{32'h0000_0413, 2'b00, 0, 0, 3, 0, 32'h3000_0004, 32'h0000_0413, 1'b0};
        tbl[1] = '{32'h0010_0093, 2'b00, 5, 0, 0, 1, 32'h3000_0100, 32'h0010_0093, 1'b0};
        tbl[2] = '{32'hDEAD_BEEF, 2'b10, 1, 2, 1, 2, 32'h3000_0200, 32'h0000_0000, 1'b1};
        tbl[3] = '{32'h1234_5678, 2'b00, 0, 1, 0, 3, 32'h3000_0300, 32'h1234_5678, 1'b0};
        tbl[4] = '{32'hCAFE_F00D, 2'b01, 2, 0, 2, 4, 32'h3000_0401, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'h0000_0013, 2'b00, 0, 3, 0, 6, 32'h3000_0500, 32'h0000_0013, 1'b0};

        rst = 1'b1; npc_valid = 1'b0; npc = 32'h0; idu_ready = 1'b0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ifu_valid", ifu_valid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_fault", ifu_fault, 0);
        chk("rst_bus", fu_to_du_bus, {RST_PC, 32'h0});
        chk("rst_arvalid", arvalid, 0);
        rst = 1'b0;
        #1;
        chk("rel_arvalid", arvalid, 1);
        chk("rel_araddr", araddr, RST_PC);

        cur = RST_PC;
        for (int i = 0; i < 6; i++) begin
            run_fetch(cur, tbl[i]);
            cur = tbl[i].pulse_pc;
        end

        // Reset during S_R with a response already on the bus
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("mid_rready", rready, 1);
        rvalid = 1'b1;
        rdata  = 32'hBAD0_BAD0;
        rst    = 1'b1;
        #1;
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_valid", ifu_valid, 0);
        step();
        rst = 1'b0;
        #1;
        model_fetch = 0;
        model_wait  = 0;
        chk("mid_rel_arvalid", arvalid, 1);
        chk("mid_rel_araddr", araddr, RST_PC);
        chk("mid_rel_rready", rready, 0);
        step();
        chk("stale_arvalid", arvalid, 1);
        chk("stale_rready", rready, 0);
        chk("stale_valid", ifu_valid, 0);
        rvalid = 1'b0;
`ifdef YSYX_25020037_IFU_PERF_EN
        chk("perf_fetch_rst", perf_fetch_cnt, 0);
        chk("perf_wait_rst", perf_wait_cnt, 0);
`endif
        cur = RST_PC;

        // Randomized fetches; the model: next address is the latest redirect
        for (int i = 0; i < 40; i++) begin
            rv.data     = $urandom;
            rv.resp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rv.ar_dly   = $urandom_range(0, 3);
            rv.r_dly    = $urandom_range(0, 3);
            rv.idu_dly  = $urandom_range(0, 3);
            rv.phase    = $urandom_range(0, 6);
            rv.pulse_pc = $urandom;
            rv.exp_inst  = (rv.resp != 2'b00) ? 32'h0 : rv.data;
            rv.exp_fault = (rv.resp != 2'b00);
            run_fetch(cur, rv);
            cur = rv.pulse_pc;
        end

`ifdef YSYX_25020037_IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'(model_fetch));
        chk("perf_wait", perf_wait_cnt, 32'(model_wait));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
